// File: rtl/neopix_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : neopix_frame_sched
// Purpose  : Frame scheduler between the SPI receive byte path and the WS2812
//            bit encoder. Received bytes are packed into 24-bit {G,R,B}
//            pixels in a ping-pong buffer. A completed frame is streamed to
//            the encoder one pixel per valid/ready handshake, followed by the
//            latch gap. A new frame may be received while the previous one
//            is being displayed.
// Ports    : CLOCK_50        - system clock, rising edge
//            rst             - synchronous active-high reset
//            rx_byte/rx_valid- received byte and its one-cycle strobe
//            rx_frame_start  - one-cycle strobe, SSEL falling edge
//            rx_frame_end    - one-cycle strobe, SSEL rising edge
//            px_data/px_valid/px_ready - pixel stream to the encoder
//            busy            - scheduler is sending or in the latch gap
//            dropped         - saturating count of frames overwritten
//                              before they were displayed
// Revision : 1.0 - initial release
// ============================================================================
module neopix_frame_sched #(
    parameter int NUM_PIXELS   = 8,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        rx_frame_start,
    input  logic        rx_frame_end,
    output logic [23:0] px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic        busy,
    output logic [7:0]  dropped
);

    // Pixel counters must reach NUM_PIXELS; RAM addresses only NUM_PIXELS-1.
    localparam int c_PW = $clog2(NUM_PIXELS + 1);
    localparam int c_AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int c_LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [c_PW-1:0] c_PIX_NUM    = c_PW'(NUM_PIXELS);
    localparam logic [c_PW-1:0] c_PIX_LAST   = c_PW'(NUM_PIXELS - 1);
    localparam logic [c_LW-1:0] c_LATCH_LAST = c_LW'(LATCH_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SEND  = 2'd1;
    localparam logic [1:0] c_ST_LATCH = 2'd2;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic            r_frame_active;
    logic [1:0]      r_byte_idx;
    logic [c_PW-1:0] r_pix_idx;
    logic [7:0]      r_byte_g;
    logic [7:0]      r_byte_r;
    logic            r_wr_bank;
    logic            r_pending;
    logic [c_PW-1:0] r_pend_count;
    logic [7:0]      r_dropped;

    // Bank is the address MSB; each bank is padded to a power of two.
    logic [23:0]     r_mem [0:(1 << (c_AW + 1)) - 1];

    logic            w_rx_take;
    logic            w_mem_we;
    logic [c_AW:0]   w_mem_waddr;
    logic [23:0]     w_mem_wdata;
    logic            w_frame_done;

    // Read side
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic            w_swap;
    logic            w_load;
    logic            w_accept;
    logic [c_PW-1:0] r_rd_count;
    logic [c_PW-1:0] r_idx;
    logic [c_LW-1:0] r_latch_cnt;
    logic            r_px_valid;
    logic [23:0]     r_px_data;
    logic [c_AW:0]   w_rd_addr;

    // A frame strobe in the same cycle as a byte takes precedence; bytes
    // past the last pixel slot are discarded.
    assign w_rx_take    = rx_valid && r_frame_active && !rx_frame_start &&
                          !rx_frame_end && (r_pix_idx != c_PIX_NUM);
    assign w_mem_we     = w_rx_take && (r_byte_idx == 2'd2);
    assign w_mem_waddr  = {r_wr_bank, r_pix_idx[c_AW-1:0]};
    assign w_mem_wdata  = {r_byte_g, r_byte_r, rx_byte};
    assign w_frame_done = rx_frame_end && !rx_frame_start && r_frame_active &&
                          (r_pix_idx != '0);

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_frame_active <= 1'b0;
            r_byte_idx     <= 2'd0;
            r_pix_idx      <= '0;
            r_byte_g       <= 8'h00;
            r_byte_r       <= 8'h00;
            r_wr_bank      <= 1'b0;
            r_pending      <= 1'b0;
            r_pend_count   <= '0;
            r_dropped      <= 8'h00;
        end else begin
            if (rx_frame_start) begin
                // Restarting abandons whatever the open frame had collected.
                r_frame_active <= 1'b1;
                r_byte_idx     <= 2'd0;
                r_pix_idx      <= '0;
            end else if (rx_frame_end) begin
                r_frame_active <= 1'b0;
                r_byte_idx     <= 2'd0;
                r_pix_idx      <= '0;
            end else if (w_rx_take) begin
                case (r_byte_idx)
                    2'd0: begin
                        r_byte_g   <= rx_byte;
                        r_byte_idx <= 2'd1;
                    end
                    2'd1: begin
                        r_byte_r   <= rx_byte;
                        r_byte_idx <= 2'd2;
                    end
                    default: begin
                        r_byte_idx <= 2'd0;
                        r_pix_idx  <= r_pix_idx + c_PW'(1);
                    end
                endcase
            end

            // A swap needs frame_active low and a frame end needs it high,
            // so the two never coincide.
            if (w_frame_done) begin
                r_pending    <= 1'b1;
                r_pend_count <= r_pix_idx;
                if (r_pending && (r_dropped != 8'hFF)) begin
                    r_dropped <= r_dropped + 8'd1;
                end
            end else if (w_swap) begin
                r_pending <= 1'b0;
            end

            if (w_swap) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Buffer contents are not reset.
    always_ff @(posedge CLOCK_50) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read side FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_swap       = 1'b0;
        w_load       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // Wait until the receiver is not filling the bank we swap in.
                if (r_pending && !r_frame_active) begin
                    w_swap       = 1'b1;
                    w_state_next = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                w_load   = !r_px_valid;
                w_accept = r_px_valid && px_ready;
                if (w_accept && (r_idx == c_PIX_LAST)) begin
                    w_state_next = c_ST_LATCH;
                end
            end
            c_ST_LATCH: begin
                if (r_latch_cnt == c_LATCH_LAST) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // The display bank is always the one not being written.
    assign w_rd_addr = {~r_wr_bank, r_idx[c_AW-1:0]};

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_rd_count  <= '0;
            r_idx       <= '0;
            r_latch_cnt <= '0;
            r_px_valid  <= 1'b0;
            r_px_data   <= 24'h0;
        end else begin
            if (w_swap) begin
                r_rd_count <= r_pend_count;
                r_idx      <= '0;
            end
            // Registered RAM read; slots past the received count show black.
            if (w_load) begin
                r_px_valid <= 1'b1;
                r_px_data  <= (r_idx < r_rd_count) ? r_mem[w_rd_addr] : 24'h0;
            end
            if (w_accept) begin
                r_px_valid  <= 1'b0;
                r_latch_cnt <= '0;
                if (r_idx != c_PIX_LAST) begin
                    r_idx <= r_idx + c_PW'(1);
                end
            end
            if (r_state == c_ST_LATCH) begin
                r_latch_cnt <= r_latch_cnt + c_LW'(1);
            end
        end
    end

    assign px_data  = r_px_data;
    assign px_valid = r_px_valid;
    assign busy     = (r_state != c_ST_IDLE);
    assign dropped  = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_neopix_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_neopix_frame_sched
// Purpose  : Self-checking bench for neopix_frame_sched (4 pixels, 2500-clock
//            latch gap). Table of frames with expected pixel streams, directed
//            multi-cycle sequences, and randomized frames checked against a
//            frame-level reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_neopix_frame_sched;

    localparam int c_N = 4;
    localparam int c_L = 2500;

    logic        CLOCK_50       = 1'b0;
    logic        rst            = 1'b1;
    logic [7:0]  rx_byte        = 8'h00;
    logic        rx_valid       = 1'b0;
    logic        rx_frame_start = 1'b0;
    logic        rx_frame_end   = 1'b0;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_ready;
    logic        busy;
    logic [7:0]  dropped;

    logic        rdy_fix  = 1'b0;
    logic        rdy_rand = 1'b0;
    logic        rdy_r    = 1'b0;
    assign px_ready = rdy_rand ? rdy_r : rdy_fix;

    neopix_frame_sched #(
        .NUM_PIXELS   (c_N),
        .LATCH_CYCLES (c_L)
    ) u_dut (
        .CLOCK_50       (CLOCK_50),
        .rst            (rst),
        .rx_byte        (rx_byte),
        .rx_valid       (rx_valid),
        .rx_frame_start (rx_frame_start),
        .rx_frame_end   (rx_frame_end),
        .px_data        (px_data),
        .px_valid       (px_valid),
        .px_ready       (px_ready),
        .busy           (busy),
        .dropped        (dropped)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(posedge CLOCK_50) begin
        #1;
        rdy_r = ($urandom_range(0, 3) != 0);
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: samples on the falling edge, so inputs (driven 1 after the
    // rising edge) and outputs are both settled. Records every accepted pixel
    // with the edge number at which it is accepted, and checks that a stalled
    // pixel stays presented unchanged.
    logic [23:0] acc_q[$];
    int          acc_edge_q[$];
    logic        hold_prev = 1'b0;
    logic [23:0] hold_data = 24'h0;

    always @(negedge CLOCK_50) begin
        if (hold_prev) begin
            chk("hold_valid", 32'(px_valid), 32'd1);
            chk("hold_data", 32'(px_data), 32'(hold_data));
        end
        hold_prev = !rst && px_valid && !px_ready;
        hold_data = px_data;
        if (!rst && px_valid && px_ready) begin
            acc_q.push_back(px_data);
            acc_edge_q.push_back(cyc + 1);
        end
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    logic [7:0]  tx_q[$];
    logic [23:0] exp_q[$];
    int          first_edge = 0;
    int          last_edge  = 0;

    task automatic send_frame(input bit do_start, input bit do_end, input int max_gap);
        if (do_start) begin
            rx_frame_start = 1'b1;
            tick();
            rx_frame_start = 1'b0;
        end
        foreach (tx_q[k]) begin
            rx_byte  = tx_q[k];
            rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            repeat ($urandom_range(0, max_gap)) tick();
        end
        if (do_end) begin
            rx_frame_end = 1'b1;
            tick();
            rx_frame_end = 1'b0;
        end
    endtask

    // Frame-level reference: complete triples of the bytes after the last
    // start, capped at the strip length, padded with black.
    task automatic model_frame(output int npix);
        npix = tx_q.size() / 3;
        if (npix > c_N) npix = c_N;
        exp_q.delete();
        for (int p = 0; p < c_N; p++) begin
            if (p < npix) exp_q.push_back({tx_q[3*p], tx_q[3*p+1], tx_q[3*p+2]});
            else          exp_q.push_back(24'h0);
        end
    endtask

    task automatic expect_frame(input string tag);
        int t;
        int fall;
        logic [23:0] got;
        t = 0;
        while ((acc_q.size() < exp_q.size()) && (t < 4000)) begin
            tick();
            t++;
        end
        chk({tag, "_arrived"}, 32'(acc_q.size() >= exp_q.size()), 32'd1);
        for (int p = 0; p < exp_q.size(); p++) begin
            if (acc_q.size() != 0) begin
                if (p == 0) first_edge = acc_edge_q[0];
                last_edge = acc_edge_q[0];
                got = acc_q.pop_front();
                acc_edge_q.delete(0);
                chk($sformatf("%s_px%0d", tag, p), 32'(got), 32'(exp_q[p]));
            end
        end
        t = 0;
        while (busy && (t < c_L + 200)) begin
            tick();
            t++;
        end
        fall = cyc;
        chk({tag, "_latch_len"}, 32'(fall - last_edge), 32'(c_L));
        chk({tag, "_valid_after"}, 32'(px_valid), 32'd0);
        chk({tag, "_no_extra"}, 32'(acc_q.size()), 32'd0);
        exp_q.delete();
    endtask

    typedef struct packed {
        logic [4:0]   nbytes;
        logic [119:0] bytes;   // first byte in the top octet
        logic [95:0]  pix;     // first pixel in the top 24 bits
    } vec_t;

    vec_t vecs [4];

    initial begin
        int t;
        int a_last;
        int npix;
        int n;
        int exp_dropped;
        vec_t cur;
        logic [7:0] bt;

        vecs[0] = '{nbytes: 5'd4,  bytes: {32'h01020304, 88'h0},
                    pix: {24'h010203, 72'h0}};
        vecs[1] = '{nbytes: 5'd15, bytes: 120'h0102030405060708090A0B0C0D0E0F,
                    pix: {24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C}};
        vecs[2] = '{nbytes: 5'd9,  bytes: {72'hFFFFFF804020123456, 48'h0},
                    pix: {24'hFFFFFF, 24'h804020, 24'h123456, 24'h0}};
        vecs[3] = '{nbytes: 5'd5,  bytes: {40'h1122334455, 80'h0},
                    pix: {24'h112233, 72'h0}};

        // Reset state
        repeat (3) tick();
        chk("rst_valid", 32'(px_valid), 32'd0);
        chk("rst_data", 32'(px_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        rst = 1'b0;
        tick();

        // Basic frame with start-up latency: end at edge N, swap at N+1,
        // first pixel presented after N+2.
        rdy_fix = 1'b0;
        tx_q = {8'hAA, 8'h55, 8'h00};
        send_frame(1'b1, 1'b1, 0);
        chk("t1_idle_at_end", 32'(busy), 32'd0);
        tick();
        chk("t1_busy_at_swap", 32'(busy), 32'd1);
        chk("t1_no_valid_at_swap", 32'(px_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(px_valid), 32'd1);
        chk("t1_data", 32'(px_data), 32'h00AA5500);
        rdy_fix = 1'b1;
        exp_q = {24'hAA5500, 24'h0, 24'h0, 24'h0};
        expect_frame("t1");
        chk("t1_dropped", 32'(dropped), 32'd0);

        // Table of frames, encoder always ready
        for (int v = 0; v < 4; v++) begin
            cur = vecs[v];
            tx_q.delete();
            for (int k = 0; k < int'(cur.nbytes); k++) begin
                bt = cur.bytes[8*(14-k) +: 8];
                tx_q.push_back(bt);
            end
            exp_q.delete();
            for (int p = 0; p < c_N; p++) exp_q.push_back(cur.pix[24*(3-p) +: 24]);
            send_frame(1'b1, 1'b1, 1);
            expect_frame($sformatf("vec%0d", v));
        end

        // Backpressure on the first pixel
        rdy_fix = 1'b0;
        tx_q = {8'h00, 8'h55, 8'hAA, 8'h11, 8'h22, 8'h33};
        send_frame(1'b1, 1'b1, 0);
        t = 0;
        while (!px_valid && (t < 20)) begin
            tick();
            t++;
        end
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("bp_valid%0d", s), 32'(px_valid), 32'd1);
            chk($sformatf("bp_data%0d", s), 32'(px_data), 32'h000055AA);
            tick();
        end
        rdy_fix = 1'b1;
        exp_q = {24'h0055AA, 24'h112233, 24'h0, 24'h0};
        expect_frame("bp");

        // Overrun: B and C both complete while A is on display
        rdy_fix = 1'b0;
        tx_q = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        send_frame(1'b1, 1'b1, 0);
        t = 0;
        while (!px_valid && (t < 20)) begin
            tick();
            t++;
        end
        chk("ovr_a_started", 32'(px_valid), 32'd1);
        tx_q = {8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9};
        send_frame(1'b1, 1'b1, 0);
        tx_q = {8'hC1, 8'hC2, 8'hC3};
        send_frame(1'b1, 1'b1, 0);
        chk("ovr_dropped", 32'(dropped), 32'd1);
        rdy_fix = 1'b1;
        exp_q = {24'hA1A2A3, 24'hA4A5A6, 24'h0, 24'h0};
        expect_frame("ovr_a");
        a_last = last_edge;
        exp_q = {24'hC1C2C3, 24'h0, 24'h0, 24'h0};
        expect_frame("ovr_c");
        chk("ovr_gap", 32'(first_edge - a_last), 32'(c_L + 3));
        chk("ovr_dropped_end", 32'(dropped), 32'd1);

        // Reset after two accepted pixels
        tx_q = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
        send_frame(1'b1, 1'b1, 0);
        t = 0;
        while ((acc_q.size() < 2) && (t < 100)) begin
            tick();
            t++;
        end
        chk("mr_two_accepts", 32'(acc_q.size()), 32'd2);
        rst = 1'b1;
        tick();
        chk("mr_valid", 32'(px_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_data", 32'(px_data), 32'd0);
        chk("mr_dropped", 32'(dropped), 32'd0);
        rst = 1'b0;
        if (acc_q.size() >= 2) begin
            chk("mr_px0", 32'(acc_q[0]), 32'h00101112);
            chk("mr_px1", 32'(acc_q[1]), 32'h00131415);
        end
        acc_q.delete();
        acc_edge_q.delete();
        repeat (50) tick();
        chk("mr_quiet", 32'(acc_q.size()), 32'd0);
        chk("mr_idle", 32'(busy), 32'd0);

        // Restart inside an open frame
        tx_q = {8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(1'b1, 1'b0, 0);
        tx_q = {8'h55, 8'h66, 8'h77};
        send_frame(1'b1, 1'b1, 0);
        exp_q = {24'h556677, 24'h0, 24'h0, 24'h0};
        expect_frame("rs");

        // Randomized frames against the frame-level model
        exp_dropped = 0;
        rdy_rand = 1'b1;
        for (int f = 0; f < 10; f++) begin
            if ($urandom_range(0, 1) == 1) begin
                rx_byte  = 8'($urandom_range(0, 255));
                rx_valid = 1'b1;
                tick();
                rx_valid = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                tx_q.delete();
                repeat ($urandom_range(1, 8)) tx_q.push_back(8'($urandom_range(0, 255)));
                send_frame(1'b1, 1'b0, 1);
            end
            tx_q.delete();
            n = $urandom_range(0, 16);
            repeat (n) tx_q.push_back(8'($urandom_range(0, 255)));
            model_frame(npix);
            send_frame(1'b1, 1'b1, 2);
            if (npix == 0) begin
                exp_q.delete();
                repeat (20) tick();
                chk($sformatf("rand%0d_idle", f), 32'(busy), 32'd0);
                chk($sformatf("rand%0d_none", f), 32'(acc_q.size()), 32'd0);
            end else begin
                expect_frame($sformatf("rand%0d", f));
            end
            chk($sformatf("rand%0d_dropped", f), 32'(dropped), 32'(exp_dropped));
        end
        rdy_rand = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
